tri_st_add_cysel_pipe: RTL and testbench
========================================

// Module: tri_st_add_cysel_pipe
// PURPOSE
//  Two-stage pipelined carry-select adder/subtractor. It consumes the 8-bit group generate/transmit
//  terms that the group-lookahead logic produces. From those terms it builds the global carries and
//  drives them back into each byte to select that byte's final sum.
//  It sits in the execution unit between operand muxing and result forwarding.
//  Valid/ready handshake on both ends; the pipeline stalls cleanly under back-pressure.
// PARAMETERS
//  WIDTH  64  operand width in bits; must be a multiple of 8 (NGRP = WIDTH/8 byte groups)
// PORTS
//  clk      in   1      clock; all state updates on rising edge
//  rst      in   1      asynchronous, active-high reset
//  i_vld    in   1      input operands valid
//  i_rdy    out  1      block can accept operands this cycle
//  i_a      in   0:W-1  operand A; bit 0 is the MSB
//  i_b      in   0:W-1  operand B; bit 0 is the MSB
//  i_cin    in   1      carry into bit W-1
//  i_sub    in   1      1 = use ~i_b (A-B when i_cin=1)
//  o_vld    out  1      result valid
//  o_rdy    in   1      downstream accepts the result
//  o_sum    out  0:W-1  result
//  o_cout   out  1      carry out of bit 0
//  o_ovf    out  1      signed overflow = carry into bit 0 XOR o_cout
// BEHAVIOUR
//  Reset (async, immediate):
//   - s1_vld=0 and s2_vld=0; all data registers are 0.
//   - o_vld=0, o_sum=0, o_cout=0, o_ovf=0.
//   - i_rdy=1 (s1 empty).
//  Handshake:
//   - Transfer occurs when vld&rdy on the same edge. i_rdy does not depend on i_vld.
//   - s2_adv = ~s2_vld | o_rdy
//   - s1_adv = ~s1_vld | s2_adv
//   - i_rdy = s1_adv (combinational path from o_rdy is allowed)
//   - s1 loads on i_vld&i_rdy. s2 loads s1 when s1_vld & s2_adv.
//   - A valid stage whose advance condition is low holds all its contents.
//  Latency and throughput:
//   - 2 cycles from accept to o_vld. Full throughput of 1 op/cycle while o_rdy=1.
//   - o_* come straight from s2 registers, with no combinational path from inputs.
//  Stage 1 (between input and s1 registers), for each byte k (k=0 is the MSB byte):
//   - bb = i_sub ? ~i_b : i_b
//   - g01 = a & bb; t01 = a | bb
//   - Compute byte sums for carry-in=0 (sum0) and carry-in=1 (sum1) using the local carry sub-module.
//   - Compute g08[k] and t08[k] with the standard 2/4/8 lookahead tree.
//   - Register sum0, sum1, g08, t08 and i_cin. Also register the byte-0 local terms needed for o_ovf.
//  Stage 2 (between s1 and s2 registers):
//   - cy[NGRP-1] = cin; cy[k] = g08[k+1] | (t08[k+1] & cy[k+1])
//   - sum byte k = cy[k] ? sum1[k] : sum0[k]
//   - o_cout = g08[0] | (t08[0] & cy[0])
//   - o_ovf = (carry into bit 0) XOR o_cout. The carry into bit 0 is selected from the byte-0 local
//     carries by cy[0].
//  Boundary cases:
//   - s1 and s2 both full with o_rdy=0 gives i_rdy=0; nothing moves and the input is ignored.
//   - Both full and o_rdy rising: s2 drains, s1 moves to s2, and a new input is accepted,
//     all on the same edge.
//   - Arithmetic is modulo 2^W: all-ones + 1 wraps to 0 with o_cout=1.
//   - Reset asserted mid-stream drops all in-flight ops; no partial result is ever presented.
//   - o_sum/o_cout/o_ovf are don't-care while o_vld=0, but must hold stable while
//     o_vld=1 & o_rdy=0.
// STRUCTURE
//  Shared package tri_st_add_pkg: localparams GRP_W=8 and NGRP(WIDTH); no typedefs required.
//  Sub-module tri_st_add_loccy (instantiate NGRP x2):
//   - inputs: g01[0:7], t01[0:7], ci
//   - outputs: s[0:7], cy[0:7] (per-bit carries into each bit)
//   - It expands the group terms back to per-bit carries.
//  The top level holds the lookahead tree, the two pipe stages and the handshake logic.
// TESTING
//  1. Reset then idle: i_rdy=1, o_vld=0 and o_sum=0 after rst deasserts;
//     async reset check by pulsing rst mid-cycle.
//  2. A=0x00000000_FFFFFFFF, B=1, cin=0, sub=0, o_rdy=1
//     -> o_vld 2 cycles later; o_sum=0x00000001_00000000, cout=0, ovf=0.
//  3. A=0xFFFFFFFF_FFFFFFFF, B=0, cin=1 -> o_sum=0, cout=1 (full-length ripple across all 8 bytes).
//  4. A=0x7FFFFFFF_FFFFFFFF, B=1, cin=0 -> o_sum=0x80000000_00000000, ovf=1.
//     Also A=5, B=7, sub=1, cin=1 -> o_sum=0xFFFFFFFF_FFFFFFFE, cout=0.
//  5. Back-pressure: stream 4 ops, hold o_rdy=0 for 3 cycles
//     -> i_rdy=0 after 2 accepts, o_* stable; release -> results in order, no loss or duplication.
//  6. Random 10k ops with random i_vld/o_rdy against a reference model (A + (sub?~B:B) + cin);
//     assert rst mid-burst -> o_vld=0 next edge and no stale result afterwards.

Source files
------------

// File: rtl/tri_st_add_pkg.sv
// Shared constants and the byte-group lookahead helper for the carry-select adder.
// The group function folds per-bit generate/transmit terms into one 8-bit group term pair.
package tri_st_add_pkg;

    localparam int GRP_W = 8;

    function automatic int ngrp(input int width);
        return width / GRP_W;
    endfunction

    // 2/4/8 lookahead tree; index 0 is the most significant bit of the group, returns {g08, t08}
    function automatic logic [1:0] grp_gt8(input logic [0:GRP_W-1] g, input logic [0:GRP_W-1] t);
        logic [0:3] g2;
        logic [0:3] t2;
        logic [0:1] g4;
        logic [0:1] t4;
        for (int i = 0; i < 4; i++) begin
            g2[i] = g[2*i] | (t[2*i] & g[2*i+1]);
            t2[i] = t[2*i] & t[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            g4[i] = g2[2*i] | (t2[2*i] & g2[2*i+1]);
            t4[i] = t2[2*i] & t2[2*i+1];
        end
        return {g4[0] | (t4[0] & g4[1]), t4[0] & t4[1]};
    endfunction

endpackage

// File: rtl/tri_st_add_cysel_pipe_loccy.sv
// Byte-local carry expansion: rebuilds per-bit carries from generate/transmit terms and a
// fixed carry-in, then forms the byte sum. Bit 0 is the MSB, so carries ripple toward index 0.
module tri_st_add_loccy
    import tri_st_add_pkg::*;
(
    input  logic [0:GRP_W-1] i_g01,
    input  logic [0:GRP_W-1] i_t01,
    input  logic             i_ci,
    output logic [0:GRP_W-1] o_s,
    output logic [0:GRP_W-1] o_cy
);

    // carry into each bit, then half-sum (t & ~g == a ^ b) xor carry
    always_comb begin
        o_cy            = '0;
        o_cy[GRP_W-1]   = i_ci;
        for (int j = GRP_W - 2; j >= 0; j--) begin
            o_cy[j] = i_g01[j+1] | (i_t01[j+1] & o_cy[j+1]);
        end
        o_s = (i_t01 & ~i_g01) ^ o_cy;
    end

endmodule

// File: rtl/tri_st_add_cysel_pipe.sv
// Two-stage carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 forms both byte sums and group terms; stage 2 resolves global carries and selects.
module tri_st_add_cysel_pipe
    import tri_st_add_pkg::*;
#(
    parameter int WIDTH = 64
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic [0:WIDTH-1] i_a,
    input  logic [0:WIDTH-1] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic [0:WIDTH-1] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NGRP = ngrp(WIDTH);

    logic [0:WIDTH-1] w_bb;
    logic [0:WIDTH-1] w_g01;
    logic [0:WIDTH-1] w_t01;
    logic [0:WIDTH-1] w_sum0;
    logic [0:WIDTH-1] w_sum1;
    logic [0:WIDTH-1] w_lcy0;
    logic [0:WIDTH-1] w_lcy1;
    logic [0:NGRP-1]  w_g08;
    logic [0:NGRP-1]  w_t08;
    logic             w_unused_lcy;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [0:NGRP-1]  w_gcy;
    logic [0:WIDTH-1] w_sum;
    logic             w_cout;
    logic             w_c_in0;
    logic             w_ovf;

    logic             r_s1_vld;
    logic [0:WIDTH-1] r_s1_sum0;
    logic [0:WIDTH-1] r_s1_sum1;
    logic [0:NGRP-1]  r_s1_g08;
    logic [0:NGRP-1]  r_s1_t08;
    logic             r_s1_cin;
    logic             r_s1_lc0;
    logic             r_s1_lc1;
    logic             r_s2_vld;
    logic [0:WIDTH-1] r_s2_sum;
    logic             r_s2_cout;
    logic             r_s2_ovf;

    assign w_bb  = i_sub ? ~i_b : i_b;
    assign w_g01 = i_a & w_bb;
    assign w_t01 = i_a | w_bb;

    for (genvar k = 0; k < NGRP; k++) begin : g_byte
        tri_st_add_loccy u_loc0 (
            .i_g01 (w_g01[k*GRP_W +: GRP_W]),
            .i_t01 (w_t01[k*GRP_W +: GRP_W]),
            .i_ci  (1'b0),
            .o_s   (w_sum0[k*GRP_W +: GRP_W]),
            .o_cy  (w_lcy0[k*GRP_W +: GRP_W])
        );
        tri_st_add_loccy u_loc1 (
            .i_g01 (w_g01[k*GRP_W +: GRP_W]),
            .i_t01 (w_t01[k*GRP_W +: GRP_W]),
            .i_ci  (1'b1),
            .o_s   (w_sum1[k*GRP_W +: GRP_W]),
            .o_cy  (w_lcy1[k*GRP_W +: GRP_W])
        );
        assign {w_g08[k], w_t08[k]} = grp_gt8(w_g01[k*GRP_W +: GRP_W], w_t01[k*GRP_W +: GRP_W]);
    end

    // only the carry into the top bit of the MSB byte is needed downstream (overflow)
    assign w_unused_lcy = ^{w_lcy0[1:WIDTH-1], w_lcy1[1:WIDTH-1]};

    assign w_s2_adv = ~r_s2_vld | o_rdy;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign i_rdy    = w_s1_adv;

    // stage 2 combinational: global group carries, byte select, carry-out and overflow
    always_comb begin
        w_gcy         = '0;
        w_sum         = '0;
        w_gcy[NGRP-1] = r_s1_cin;
        for (int k = NGRP - 2; k >= 0; k--) begin
            w_gcy[k] = r_s1_g08[k+1] | (r_s1_t08[k+1] & w_gcy[k+1]);
        end
        for (int k = 0; k < NGRP; k++) begin
            if (w_gcy[k]) begin
                w_sum[k*GRP_W +: GRP_W] = r_s1_sum1[k*GRP_W +: GRP_W];
            end else begin
                w_sum[k*GRP_W +: GRP_W] = r_s1_sum0[k*GRP_W +: GRP_W];
            end
        end
        w_cout  = r_s1_g08[0] | (r_s1_t08[0] & w_gcy[0]);
        w_c_in0 = w_gcy[0] ? r_s1_lc1 : r_s1_lc0;
        w_ovf   = w_c_in0 ^ w_cout;
    end

    // stage 1 registers: both candidate sums, group terms and MSB-byte local carries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_sum0 <= '0;
            r_s1_sum1 <= '0;
            r_s1_g08  <= '0;
            r_s1_t08  <= '0;
            r_s1_cin  <= 1'b0;
            r_s1_lc0  <= 1'b0;
            r_s1_lc1  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= i_vld;
            if (i_vld) begin
                r_s1_sum0 <= w_sum0;
                r_s1_sum1 <= w_sum1;
                r_s1_g08  <= w_g08;
                r_s1_t08  <= w_t08;
                r_s1_cin  <= i_cin;
                r_s1_lc0  <= w_lcy0[0];
                r_s1_lc1  <= w_lcy1[0];
            end
        end
    end

    // stage 2 registers drive the outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_sum  <= '0;
            r_s2_cout <= 1'b0;
            r_s2_ovf  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sum  <= w_sum;
                r_s2_cout <= w_cout;
                r_s2_ovf  <= w_ovf;
            end
        end
    end

    assign o_vld  = r_s2_vld;
    assign o_sum  = r_s2_sum;
    assign o_cout = r_s2_cout;
    assign o_ovf  = r_s2_ovf;

endmodule

// File: tb/tb_tri_st_add_cysel_pipe.sv
// Self-checking bench: directed corner cases, back-pressure, and randomized traffic
// against an arithmetic reference model with an in-order expectation queue.
module tb_tri_st_add_cysel_pipe;

    logic        clk;
    logic        rst;
    logic        i_vld;
    logic        i_rdy;
    logic [0:63] i_a;
    logic [0:63] i_b;
    logic        i_cin;
    logic        i_sub;
    logic        o_vld;
    logic        o_rdy;
    logic [0:63] o_sum;
    logic        o_cout;
    logic        o_ovf;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_popped = 0;
    logic [65:0] exp_q[$];
    logic [65:0] e;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_sum;
    logic [1:0]  prev_flags;

    tri_st_add_cysel_pipe #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_cin  (i_cin),
        .i_sub  (i_sub),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy),
        .o_sum  (o_sum),
        .o_cout (o_cout),
        .o_ovf  (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference: plain modulo-2^64 add, signed overflow from operand/result signs; {ovf,cout,sum}
    function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
        logic [63:0] bb;
        logic [64:0] full;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
        ovf  = (a[63] == bb[63]) && (full[63] != a[63]);
        return {ovf, full[64], full[63:0]};
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'd0;
            2:       v = {32'd0, $urandom()};
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // scoreboard and output-hold monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && o_vld) begin
                chk("hold_sum", o_sum, prev_sum);
                chk("hold_flags", {62'd0, o_cout, o_ovf}, {62'd0, prev_flags});
            end
            if (o_vld && o_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious_vld", {63'd0, o_vld}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", o_sum, e[63:0]);
                    chk("sb_cout", {63'd0, o_cout}, {63'd0, e[64]});
                    chk("sb_ovf", {63'd0, o_ovf}, {63'd0, e[65]});
                    n_popped++;
                end
            end
            if (i_vld && i_rdy) exp_q.push_back(ref_add(i_a, i_b, i_cin, i_sub));
            prev_hold  = o_vld & ~o_rdy;
            prev_sum   = o_sum;
            prev_flags = {o_cout, o_ovf};
        end
    end

    task automatic run_one(input string tag, input logic [63:0] a_v, input logic [63:0] b_v,
                           input logic cin_v, input logic sub_v, input logic [63:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
        int lat;
        @(posedge clk); #1;
        i_a = a_v; i_b = b_v; i_cin = cin_v; i_sub = sub_v; i_vld = 1'b1; o_rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_irdy"}, {63'd0, i_rdy}, 64'd1);
        @(posedge clk); #1;
        i_vld = 1'b0;
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (o_vld) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_sum"}, o_sum, exp_sum);
        chk({tag, "_cout"}, {63'd0, o_cout}, {63'd0, exp_cout});
        chk({tag, "_ovf"}, {63'd0, o_ovf}, {63'd0, exp_ovf});
    endtask

    initial begin
        int  sent;
        int  stall_cyc;
        int  popped0;
        bit  saw;
        bit  acc;
        rst = 1'b1; i_vld = 1'b0; o_rdy = 1'b0;
        i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_irdy", {63'd0, i_rdy}, 64'd1);
        chk("rst_ovld", {63'd0, o_vld}, 64'd0);
        chk("rst_osum", o_sum, 64'd0);

        run_one("carry32", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        run_one("ripple",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_one("ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_one("sub",     64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        // async reset while a result is held at the output
        @(posedge clk); #1;
        o_rdy = 1'b0; i_a = 64'd9; i_b = 64'd3; i_cin = 1'b0; i_sub = 1'b0; i_vld = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_pre_rst_vld", {63'd0, o_vld}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_vld", {63'd0, o_vld}, 64'd0);
        chk("async_rst_sum", o_sum, 64'd0);
        chk("async_rst_irdy", {63'd0, i_rdy}, 64'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // back-pressure: four ops, output stalled for three cycles once the pipe is full
        @(posedge clk); #1;
        o_rdy = 1'b0; sent = 0; stall_cyc = 0; saw = 1'b0; popped0 = n_popped;
        for (int c = 0; c < 20; c++) begin
            i_vld = (sent < 4);
            i_a = rnd_operand(); i_b = rnd_operand();
            i_cin = 1'($urandom_range(0, 1)); i_sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = i_vld & i_rdy;
            if (!i_rdy && !saw) begin
                saw = 1'b1;
                chk("bp_accepts_before_stall", 64'(sent), 64'd2);
            end
            if (saw && !o_rdy) stall_cyc++;
            @(posedge clk); #1;
            if (acc) sent++;
            if (saw && stall_cyc >= 3) o_rdy = 1'b1;
        end
        i_vld = 1'b0;
        chk("bp_stall_seen", {63'd0, saw}, 64'd1);
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_delivered", 64'(n_popped - popped0), 64'd4);

        // randomized traffic with a reset dropped into the middle of the burst
        for (int cyc = 0; cyc < 12000; cyc++) begin
            i_vld = ($urandom_range(0, 99) < 80);
            i_a = rnd_operand(); i_b = rnd_operand();
            i_cin = 1'($urandom_range(0, 1)); i_sub = 1'($urandom_range(0, 1));
            o_rdy = ($urandom_range(0, 99) < 75);
            if (cyc == 6000) begin
                i_vld = 1'b1; o_rdy = 1'b0;
                repeat (3) @(posedge clk);
                #3 rst = 1'b1;
                i_vld = 1'b0;
                #1;
                chk("mid_rst_vld", {63'd0, o_vld}, 64'd0);
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
                chk("post_rst_vld", {63'd0, o_vld}, 64'd0);
            end
            @(posedge clk); #1;
        end

        i_vld = 1'b0; o_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("random_activity", 64'(n_popped > 5000), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
